// File: rtl/butterfly1_pipe.sv
// First-stage even-part butterfly for the forward core transform.
// It has four registered levels (L32, L16, L8, L4), valid/ready flow control and per-block beat tracking.
module butterfly1_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_transize,
    input  logic                  i_inverse,
    input  logic [32*IN_W-1:0]    i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [32*OUT_W-1:0]   o_data,
    output logic [1:0]            o_transize,
    output logic                  o_inverse,
    output logic [4:0]            o_beat_idx,
    output logic                  o_last
);

    localparam int LANES = 32;

    // Bit offset of level l in the chain of lane vectors.
    // Level 0 is the input. Level l has lanes of width IN_W+l.
    function automatic int lvl_base(input int l);
        return LANES * (l * IN_W + (l * (l - 1)) / 2);
    endfunction

    // Bit t says whether a lane sits in the butterflied low part of its segment.
    // This is evaluated for a level-m stage when the block size is 4<<t.
    function automatic logic [3:0] seg_mask(input int lane, input int m);
        logic [3:0] r;
        for (int t = 0; t < 4; t++) begin
            r[t] = ((4 << t) >= m) && ((lane % (4 << t)) < m);
        end
        return r;
    endfunction

    localparam int B1     = lvl_base(1);
    localparam int B4     = lvl_base(4);
    localparam int PIPE_W = lvl_base(5) - B1;

    logic [PIPE_W-1:0] pipe_reg;
    wire  [PIPE_W-1:0] pipe_next;
    logic [B4-1:0]     chain;

    logic [4:1] vld_reg;
    logic [1:0] ts_reg   [1:4];
    logic       inv_reg  [1:4];
    logic [4:0] idx_reg  [1:4];
    logic       last_reg [1:4];

    logic [4:0] cnt_reg;
    logic [1:0] ts_lat_reg;
    logic       inv_lat_reg;

    logic       adv;
    logic       accept;
    logic [1:0] eff_ts;
    logic       eff_inv;
    logic [4:0] beats_m1;
    logic       eff_last;
    logic [1:0] ts_in  [1:4];
    logic       inv_in [1:4];

    assign adv     = ~vld_reg[4] | i_ready;
    assign accept  = i_valid & adv;
    assign o_ready = adv;

    // Size and inverse are taken from the inputs only on the first beat of a block.
    assign eff_ts  = (cnt_reg == 5'd0) ? i_transize : ts_lat_reg;
    assign eff_inv = (cnt_reg == 5'd0) ? i_inverse  : inv_lat_reg;

    always_comb begin
        beats_m1 = 5'd0;
        case (eff_ts)
            2'd0: beats_m1 = 5'd0;
            2'd1: beats_m1 = 5'd1;
            2'd2: beats_m1 = 5'd7;
            default: beats_m1 = 5'd31;
        endcase
    end

    assign eff_last = (cnt_reg == beats_m1);

    always_comb begin
        ts_in[1]  = eff_ts;
        inv_in[1] = eff_inv;
        for (int l = 2; l <= 4; l++) begin
            ts_in[l]  = ts_reg[l-1];
            inv_in[l] = inv_reg[l-1];
        end
    end

    assign chain = {pipe_reg[B4-B1-1:0], i_data};

    for (genvar gl = 1; gl <= 4; gl++) begin : g_lvl
        localparam int M  = 64 >> gl;
        localparam int WI = IN_W + gl - 1;
        localparam int WO = IN_W + gl;
        localparam int IB = lvl_base(gl - 1);
        localparam int OB = lvl_base(gl) - B1;

        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int         J   = gi % M;
            localparam int         P   = gi - J + M - 1 - J;
            localparam logic [3:0] SEG = seg_mask(gi, M);

            logic signed [WO-1:0] a_ext;
            logic signed [WO-1:0] b_ext;
            logic signed [WO-1:0] res;

            assign a_ext = {chain[IB + gi*WI + WI - 1], chain[IB + gi*WI +: WI]};
            assign b_ext = {chain[IB + P*WI + WI - 1],  chain[IB + P*WI +: WI]};

            // The low half of a span takes the mirrored sum.
            // The high half takes the mirrored difference (low minus high).
            always_comb begin
                res = a_ext;
                if (!inv_in[gl] && SEG[ts_in[gl]]) begin
                    res = (J < M/2) ? (a_ext + b_ext) : (b_ext - a_ext);
                end
            end

            assign pipe_next[OB + gi*WO +: WO] = res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_reg    <= '0;
            vld_reg     <= '0;
            cnt_reg     <= 5'd0;
            ts_lat_reg  <= 2'd0;
            inv_lat_reg <= 1'b0;
            for (int l = 1; l <= 4; l++) begin
                ts_reg[l]   <= 2'd0;
                inv_reg[l]  <= 1'b0;
                idx_reg[l]  <= 5'd0;
                last_reg[l] <= 1'b0;
            end
        end else begin
            if (adv) begin
                pipe_reg    <= pipe_next;
                vld_reg[1]  <= i_valid;
                ts_reg[1]   <= eff_ts;
                inv_reg[1]  <= eff_inv;
                idx_reg[1]  <= cnt_reg;
                last_reg[1] <= eff_last;
                for (int l = 2; l <= 4; l++) begin
                    vld_reg[l]  <= vld_reg[l-1];
                    ts_reg[l]   <= ts_reg[l-1];
                    inv_reg[l]  <= inv_reg[l-1];
                    idx_reg[l]  <= idx_reg[l-1];
                    last_reg[l] <= last_reg[l-1];
                end
            end
            if (accept) begin
                if (cnt_reg == 5'd0) begin
                    ts_lat_reg  <= i_transize;
                    inv_lat_reg <= i_inverse;
                end
                cnt_reg <= eff_last ? 5'd0 : cnt_reg + 5'd1;
            end
        end
    end

    assign o_valid    = vld_reg[4];
    assign o_data     = pipe_reg[PIPE_W-1 -: 32*OUT_W];
    assign o_transize = ts_reg[4];
    assign o_inverse  = inv_reg[4];
    assign o_beat_idx = idx_reg[4];
    assign o_last     = last_reg[4];

endmodule

// File: tb/tb_butterfly1_pipe.sv
// Scoreboard bench for butterfly1_pipe.
// Accepted beats push reference results into a queue, and a negedge monitor pops and compares them.
module tb_butterfly1_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 20;

    logic                 clk;
    logic                 rst;
    logic                 i_valid;
    logic                 o_ready;
    logic [1:0]           i_transize;
    logic                 i_inverse;
    logic [32*IN_W-1:0]   i_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [32*OUT_W-1:0]  o_data;
    logic [1:0]           o_transize;
    logic                 o_inverse;
    logic [4:0]           o_beat_idx;
    logic                 o_last;

    butterfly1_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_transize(i_transize), .i_inverse(i_inverse), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_transize(o_transize), .o_inverse(o_inverse),
        .o_beat_idx(o_beat_idx), .o_last(o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [32*OUT_W-1:0] data;
        logic [1:0]          ts;
        logic                inv;
        logic [4:0]          idx;
        logic                last;
        logic [2:0]          tag;
        logic                lat;
        int                  pcyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_push;
    exp_t e_pop;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int bp_mode = 0;
    int cur_tag = 0;
    bit lat_chk = 0;

    int         mcnt = 0;
    logic [1:0] mts  = 2'd0;
    logic       minv = 1'b0;

    bit                  held = 0;
    logic [32*OUT_W-1:0] held_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chkv(input string name, input logic [32*OUT_W-1:0] act,
                        input logic [32*OUT_W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int beats_of(input logic [1:0] ts);
        case (ts)
            2'd0: return 1;
            2'd1: return 2;
            2'd2: return 8;
            default: return 32;
        endcase
    endfunction

    // The reference works on whole rows.
    // For each N-lane segment, it folds lanes b..b+m-1 for m = N, N/2, ..., 4.
    function automatic logic [32*OUT_W-1:0] ref_beat(input logic [32*IN_W-1:0] d,
                                                     input logic [1:0] ts, input logic inv);
        int x[32];
        int n;
        int t0;
        int t1;
        logic signed [IN_W-1:0] s;
        logic [32*OUT_W-1:0] r;
        for (int k = 0; k < 32; k++) begin
            s = d[k*IN_W +: IN_W];
            x[k] = s;
        end
        n = 4 << ts;
        if (!inv) begin
            for (int b = 0; b < 32; b += n) begin
                for (int m = n; m >= 4; m = m / 2) begin
                    for (int j = 0; j < m/2; j++) begin
                        t0 = x[b+j];
                        t1 = x[b+m-1-j];
                        x[b+j]     = t0 + t1;
                        x[b+m-1-j] = t0 - t1;
                    end
                end
            end
        end
        for (int k = 0; k < 32; k++) r[k*OUT_W +: OUT_W] = x[k][OUT_W-1:0];
        return r;
    endfunction

    // These are the known results for the ramp input i_k = k at each block size.
    function automatic logic [32*OUT_W-1:0] spec_vec(input int tag);
        int v[32];
        logic [32*OUT_W-1:0] r;
        for (int k = 0; k < 32; k++) v[k] = 0;
        if (tag == 1) begin
            v[0] = 248;
            v[1] = 248;
            for (int m = 0; m < 16; m++) v[16+m] = -(2*m + 1);
        end else if (tag == 2) begin
            for (int s = 0; s < 4; s++) begin
                v[8*s]   = 32*s + 14;
                v[8*s+1] = 32*s + 14;
                for (int q = 0; q < 4; q++) v[8*s+4+q] = -(2*q + 1);
            end
        end else begin
            for (int s = 0; s < 8; s++) begin
                v[4*s]   = 8*s + 3;
                v[4*s+1] = 8*s + 3;
                v[4*s+2] = -1;
                v[4*s+3] = -3;
            end
        end
        for (int k = 0; k < 32; k++) r[k*OUT_W +: OUT_W] = v[k][OUT_W-1:0];
        return r;
    endfunction

    // The monitor and the scoreboard push run on the falling edge, when all signals are settled.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            mcnt = 0;
            mts  = 2'd0;
            minv = 1'b0;
            held = 0;
        end else begin
            if (held) begin
                chkv("stall_hold_data", o_data, held_data);
                chk("stall_hold_valid", o_valid, 1);
            end
            held = 0;
            if (o_valid && !i_ready) begin
                chk("ready_drop", o_ready, 0);
                held      = 1;
                held_data = o_data;
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got beat idx %0d expected none", o_beat_idx);
                end else begin
                    e_pop = sb.pop_front();
                    chkv("data", o_data, e_pop.data);
                    chk("transize", o_transize, e_pop.ts);
                    chk("inverse", o_inverse, e_pop.inv);
                    chk("beat_idx", o_beat_idx, e_pop.idx);
                    chk("last", o_last, e_pop.last);
                    if (e_pop.lat) chk("latency", cyc - e_pop.pcyc, 4);
                    if (e_pop.tag >= 3'd1 && e_pop.tag <= 3'd3)
                        chkv("ramp_const", o_data, spec_vec(int'(e_pop.tag)));
                    if (e_pop.tag == 3'd4) chk("idx_after_rst", o_beat_idx, 0);
                end
            end
            if (i_valid && o_ready) begin
                if (mcnt == 0) begin
                    mts  = i_transize;
                    minv = i_inverse;
                end
                e_push.ts   = mts;
                e_push.inv  = minv;
                e_push.idx  = 5'(mcnt);
                e_push.last = (mcnt == beats_of(mts) - 1);
                e_push.data = ref_beat(i_data, mts, minv);
                e_push.tag  = 3'(cur_tag);
                e_push.lat  = lat_chk;
                e_push.pcyc = cyc;
                mcnt = e_push.last ? 0 : mcnt + 1;
                sb.push_back(e_push);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0: i_ready = 1'b1;
                1: i_ready = ~i_ready;
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [32*IN_W-1:0] ramp_beat();
        logic [32*IN_W-1:0] d;
        for (int k = 0; k < 32; k++) d[k*IN_W +: IN_W] = IN_W'(k);
        return d;
    endfunction

    function automatic logic [32*IN_W-1:0] rand_beat();
        logic [32*IN_W-1:0] d;
        for (int k = 0; k < 32; k++) begin
            case ($urandom_range(0, 3))
                0: d[k*IN_W +: IN_W] = 16'h7fff;
                1: d[k*IN_W +: IN_W] = 16'h8000;
                default: d[k*IN_W +: IN_W] = IN_W'($urandom);
            endcase
        end
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_beat(input logic [1:0] ts, input logic inv,
                              input logic [32*IN_W-1:0] d, input int tag);
        bit ok;
        bit done;
        i_valid    = 1'b1;
        i_transize = ts;
        i_inverse  = inv;
        i_data     = d;
        cur_tag    = tag;
        done       = 0;
        for (int w = 0; w < 1000 && !done; w++) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        i_valid = 1'b0;
        cur_tag = 0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 400) begin
            idle(1);
            w++;
        end
        chk("drain_pending", sb.size(), 0);
        idle(6);
    endtask

    initial begin
        logic [32*IN_W-1:0] d;
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_transize = 2'd0;
        i_inverse  = 1'b0;
        i_data     = '0;
        idle(3);
        chk("rst_o_valid", o_valid, 0);
        chkv("rst_o_data", o_data, '0);
        chk("rst_o_transize", o_transize, 0);
        chk("rst_o_inverse", o_inverse, 0);
        chk("rst_o_beat_idx", o_beat_idx, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_o_ready", o_ready, 1);
        rst = 1'b0;
        idle(1);

        // Ramp blocks, unstalled, with the latency checked.
        lat_chk = 1;
        for (int b = 0; b < 32; b++) drive_beat(2'd3, 1'b0, ramp_beat(), (b == 0) ? 1 : 0);
        for (int b = 0; b < 2; b++) drive_beat(2'd1, 1'b0, ramp_beat(), 2);
        for (int b = 0; b < 3; b++) drive_beat(2'd0, 1'b0, ramp_beat(), 3);
        drain();
        lat_chk = 0;

        // Inverse bypass on 16x16 with extreme lane values.
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 32; k++)
                d[k*IN_W +: IN_W] = ((k + b) % 2 == 0) ? 16'h7fff : 16'h8000;
            drive_beat(2'd2, 1'b1, d, 0);
        end
        drain();

        // Ten back-to-back beats while i_ready toggles.
        bp_mode = 1;
        for (int b = 0; b < 10; b++) drive_beat(2'd1, 1'b0, rand_beat(), 0);
        drain();

        // Random sizes, flags, gaps and backpressure. Mid-block size changes must be ignored.
        bp_mode = 2;
        for (int b = 0; b < 80; b++) begin
            drive_beat(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_beat(), 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();
        bp_mode = 0;
        idle(2);

        // A reset pulse clears any partial block. Then a 32x32 block changes size at beat 5 and is reset at beat 12.
        rst = 1'b1;
        idle(1);
        chk("rst_pulse_valid", o_valid, 0);
        rst = 1'b0;
        for (int b = 0; b < 12; b++)
            drive_beat((b < 5) ? 2'd3 : 2'($urandom_range(0, 2)), 1'b0, rand_beat(), 0);
        rst     = 1'b1;
        i_valid = 1'b1;
        idle(1);
        chk("rst_mid_valid", o_valid, 0);
        rst     = 1'b0;
        i_valid = 1'b0;
        drive_beat(2'd3, 1'b0, ramp_beat(), 4);
        drive_beat(2'd3, 1'b0, rand_beat(), 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
